// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX FIFO default depth, TX FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int TXF_DEPTH_DEF  = 16;
    localparam int TXF_ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        TXF_IDLE  = 2'd0,
        TXF_ISSUE = 2'd1,
        TXF_WAIT  = 2'd2
    } txf_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// TX FIFO storage: DEPTH x UART_DATA_W, synchronous write, asynchronous head read.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXF_DEPTH_DEF,
    parameter int ADDR_W = TXF_ADDR_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    // Write the pushed byte into its slot; storage needs no reset.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers CSR byte writes and hands them one at a time to the
// bit-serialiser over the tx_data/tx_wr/tx_done handshake.
// Optional feature: define UART_TXFIFO_FLUSH_EN to add the flush input.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TXF_IDLE  | nothing in flight; pops the head as soon as the FIFO is non-empty
// TXF_ISSUE | tx_data loaded; tx_wr pulses for this single cycle
// TXF_WAIT  | serialiser busy; on tx_done pop the next byte or return to idle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXF_DEPTH_DEF,
    parameter int ADDR_W = TXF_ADDR_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   tx_idle,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_wr,
`ifdef UART_TXFIFO_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   tx_done
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]        wr_ptr;
    logic [ADDR_W:0]        rd_ptr;
    logic [UART_DATA_W-1:0] head;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   flush_i;
    txf_state_t             state;
    txf_state_t             state_nxt;

`ifdef UART_TXFIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign tx_idle = empty && (state == TXF_IDLE);

    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated, whose old byte is captured by tx_data.
    assign push = wr_en && !flush_i && (!full || pop);
    assign drop = wr_en && !flush_i && full && !pop;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .we      (push),
        .waddr   (wr_ptr[ADDR_W-1:0]),
        .wdata   (wr_data),
        .raddr   (rd_ptr[ADDR_W-1:0]),
        .rdata   (head)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= TXF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, pop request and start pulse; a flush blocks any new pop.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_wr     = 1'b0;
        case (state)
            TXF_IDLE: begin
                if (!empty && !flush_i) begin
                    pop       = 1'b1;
                    state_nxt = TXF_ISSUE;
                end
            end
            TXF_ISSUE: begin
                tx_wr     = 1'b1;
                state_nxt = TXF_WAIT;
            end
            TXF_WAIT: begin
                if (tx_done) begin
                    if (!empty && !flush_i) begin
                        pop       = 1'b1;
                        state_nxt = TXF_ISSUE;
                    end else begin
                        state_nxt = TXF_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = TXF_IDLE;
            end
        endcase
    end

    // Read/write pointers; flush discards everything queued by catching rd up to wr.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (flush_i) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow flag; a dropped push outranks a same-cycle clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr || flush_i) begin
            ovf <= 1'b0;
        end
    end

    // Capture the head on pop; held until the next pop so it is stable through tx_done.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= head;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of expected tx bytes checked by a
// monitor on every tx_wr, plus directed checks of flags, level and timing.
module tb_uart_tx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx_done = 1'b0;
`ifdef UART_TXFIFO_FLUSH_EN
    logic       flush   = 1'b0;
`endif
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       tx_idle;
    logic [7:0] tx_data;
    logic       tx_wr;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    int         wr_times[$];

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .tx_idle (tx_idle),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
`ifdef UART_TXFIFO_FLUSH_EN
        .flush   (flush),
`endif
        .tx_done (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_tx) exp_q.push_back(b);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_tx_wr(input string name);
        int n;
        n = 0;
        while (tx_wr !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check({name, "_timeout"}, {31'd0, tx_wr}, 32'd1);
    endtask

    // Serialiser model: finish each byte `gap` idle cycles after the WAIT cycle.
    task automatic serve(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            wait_tx_wr("serve");
            tick();
            repeat (gap) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    // Monitor: every tx_wr must carry the next byte from the scoreboard.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (tx_wr === 1'b1) begin
                wr_times.push_back(cyc);
                if (exp_q.size() == 0) check("tx_wr_spurious", {31'd0, tx_wr}, 32'd0);
                else                   check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        sys_rst = 1'b0;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);

        // Single byte: tx_wr two cycles after the push, then idle after tx_done
        push_byte(8'h55, 1'b1);
        check("t1_n1_tx_wr", {31'd0, tx_wr}, 32'd0);
        check("t1_n1_level", {27'd0, level}, 32'd1);
        tick();
        check("t1_n2_tx_wr", {31'd0, tx_wr}, 32'd1);
        check("t1_n2_level", {27'd0, level}, 32'd0);
        check("t1_n2_tx_idle", {31'd0, tx_idle}, 32'd0);
        repeat (9) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t1_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("t1_level", {27'd0, level}, 32'd0);

        // Fill: 0x01 goes in flight, 0x02..0x11 fill all 16 entries
        for (int i = 1; i <= 17; i++) push_byte(i[7:0], 1'b1);
        check("t2_full", {31'd0, full}, 32'd1);
        check("t2_level", {27'd0, level}, 32'd16);
        check("t2_ovf_before", {31'd0, ovf}, 32'd0);
        push_byte(8'hAA, 1'b0);
        check("t2_ovf_set", {31'd0, ovf}, 32'd1);
        check("t2_level_drop", {27'd0, level}, 32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t2_ovf_clr", {31'd0, ovf}, 32'd0);
        wr_en = 1'b1; wr_data = 8'hBB; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("t2_ovf_set_wins", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t2_ovf_clr2", {31'd0, ovf}, 32'd0);

        // Full FIFO: push coincident with tx_done-driven pop is accepted
        tx_done = 1'b1; wr_en = 1'b1; wr_data = 8'h12;
        exp_q.push_back(8'h12);
        tick();
        tx_done = 1'b0; wr_en = 1'b0;
        check("t3_level", {27'd0, level}, 32'd16);
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_ovf", {31'd0, ovf}, 32'd0);
        check("t3_tx_wr", {31'd0, tx_wr}, 32'd1);
        serve(17, 0);
        check("t3_drain_idle", {31'd0, tx_idle}, 32'd1);
        check("t3_drain_level", {27'd0, level}, 32'd0);
        check("t3_drain_sb", exp_q.size(), 32'd0);

        // Spacing: tx_done one idle cycle after WAIT -> tx_wr every 3 cycles
        wr_times.delete();
        fork
            begin
                push_byte(8'h10, 1'b1);
                push_byte(8'h20, 1'b1);
                push_byte(8'h30, 1'b1);
            end
            serve(3, 1);
        join
        check("t4_num_tx_wr", wr_times.size(), 32'd3);
        if (wr_times.size() == 3) begin
            check("t4_gap1", wr_times[1] - wr_times[0], 32'd3);
            check("t4_gap2", wr_times[2] - wr_times[1], 32'd3);
        end
        tick();
        check("t4_idle", {31'd0, tx_idle}, 32'd1);

        // Reset while in WAIT with 5 bytes queued
        push_byte(8'h61, 1'b1);
        for (int i = 2; i <= 6; i++) push_byte(8'h60 + i[7:0], 1'b0);
        check("t5_level_pre", {27'd0, level}, 32'd5);
        check("t5_busy_pre", {31'd0, tx_idle}, 32'd0);
        sys_rst = 1'b1;
        tick();
        check("t5_level", {27'd0, level}, 32'd0);
        check("t5_tx_wr", {31'd0, tx_wr}, 32'd0);
        check("t5_tx_idle", {31'd0, tx_idle}, 32'd1);
        sys_rst = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (5) tick();
        check("t5_late_done_idle", {31'd0, tx_idle}, 32'd1);
        check("t5_late_done_level", {27'd0, level}, 32'd0);

`ifdef UART_TXFIFO_FLUSH_EN
        // Flush with 8 queued and 0x01 in flight
        push_byte(8'h01, 1'b1);
        for (int i = 2; i <= 9; i++) push_byte(i[7:0], 1'b0);
        check("t6_level_pre", {27'd0, level}, 32'd8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_level", {27'd0, level}, 32'd0);
        check("t6_empty", {31'd0, empty}, 32'd1);
        check("t6_inflight", {31'd0, tx_idle}, 32'd0);
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t6_no_tx_wr", {31'd0, tx_wr}, 32'd0);
            tick();
        end
        check("t6_tx_idle", {31'd0, tx_idle}, 32'd1);
`endif

        check("final_sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
